// File: rtl/encoder_16to4.sv
// encoder_16to4
//   Registered 16-to-4 priority encoder. Converts a request vector into the
//   index of the winning set bit, with a valid flag and a multi-hot flag.
//   One clock of latency; every output comes straight from a flop.
//
// Parameters
//   MSB_PRIORITY : 1 -> highest-numbered set bit wins, 0 -> lowest wins.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset, clears all outputs
//   input_16  in   [15:0] request vector, bit i = index i requesting
//   enable    in   encode enable, sampled on the clk rising edge
//   out       out  [3:0] registered index of the winning bit (0 when idle)
//   valid     out  registered: last enabled sample had at least one bit set
//   multi_hot out  registered: last enabled sample had two or more bits set
module encoder_16to4 #(
    parameter bit MSB_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] input_16,
    input  logic        enable,
    output logic [3:0]  out,
    output logic        valid,
    output logic        multi_hot
);

    logic [3:0] idx;
    logic       any_set;
    logic       many_set;

    // Priority scan: the last assignment in loop order wins, so the scan
    // direction picks which end of the vector has priority.
    always_comb begin
        idx = 4'h0;
        if (MSB_PRIORITY) begin
            for (int i = 0; i < 16; i++)
                if (input_16[i]) idx = 4'(i);
        end else begin
            for (int i = 15; i >= 0; i--)
                if (input_16[i]) idx = 4'(i);
        end
    end

    assign any_set  = |input_16;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign many_set = |(input_16 & (input_16 - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= 4'h0;
            valid     <= 1'b0;
            multi_hot <= 1'b0;
        end else if (enable && any_set) begin
            out       <= idx;
            valid     <= 1'b1;
            multi_hot <= many_set;
        end else begin
            out       <= 4'h0;
            valid     <= 1'b0;
            multi_hot <= 1'b0;
        end
    end

endmodule

// File: tb/tb_encoder_16to4.sv
module tb_encoder_16to4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] input_16;
    logic        enable;
    logic [3:0]  out_m, out_l;
    logic        valid_m, valid_l, mh_m, mh_l;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    encoder_16to4 #(.MSB_PRIORITY(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .input_16(input_16), .enable(enable),
        .out(out_m), .valid(valid_m), .multi_hot(mh_m)
    );

    encoder_16to4 #(.MSB_PRIORITY(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .input_16(input_16), .enable(enable),
        .out(out_l), .valid(valid_l), .multi_hot(mh_l)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: collect the indices of all set bits, then pick the end
    // of the list that has priority; multi-hot is simply list length >= 2.
    function automatic void model(input logic [15:0] v, input logic en, input bit msb,
                                  output int o, output int vl, output int mh);
        int hits[$];
        for (int i = 0; i < 16; i++) if (v[i]) hits.push_back(i);
        if (!en || hits.size() == 0) begin
            o = 0; vl = 0; mh = 0;
        end else begin
            o  = msb ? hits[hits.size()-1] : hits[0];
            vl = 1;
            mh = (hits.size() >= 2) ? 1 : 0;
        end
    endfunction

    // Drive at negedge, sample #1 after the next rising edge, compare both
    // instances against the model.
    task automatic step(input logic [15:0] v, input logic en, input string tag);
        int eo, ev, em;
        @(negedge clk);
        input_16 = v;
        enable   = en;
        @(posedge clk);
        #1;
        model(v, en, 1'b1, eo, ev, em);
        chk({tag, ".msb.out"},   int'(out_m), eo);
        chk({tag, ".msb.valid"}, int'(valid_m), ev);
        chk({tag, ".msb.mh"},    int'(mh_m), em);
        model(v, en, 1'b0, eo, ev, em);
        chk({tag, ".lsb.out"},   int'(out_l), eo);
        chk({tag, ".lsb.valid"}, int'(valid_l), ev);
        chk({tag, ".lsb.mh"},    int'(mh_l), em);
    endtask

    logic [15:0] tbl_in  [5] = '{16'h0005, 16'h0210, 16'h2020, 16'h0680, 16'hFFFF};
    int          tbl_msb [5] = '{2, 9, 13, 10, 15};
    logic [15:0] tbl0_in [5] = '{16'h0005, 16'h0210, 16'h2020, 16'h0680, 16'h8000};
    int          tbl0_o  [5] = '{0, 4, 5, 7, 15};
    int          tbl0_mh [5] = '{1, 1, 1, 1, 0};

    initial begin
        rst_n    = 1'b0;
        input_16 = 16'hFFFF;
        enable   = 1'b1;

        // Reset holds outputs low even with a full enabled request
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out",   int'(out_m), 0);
        chk("rst.valid", int'(valid_m), 0);
        chk("rst.mh",    int'(mh_m), 0);
        chk("rst.lsb.valid", int'(valid_l), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-hot walk
        for (int i = 0; i < 16; i++) begin
            step(16'h1 << i, 1'b1, "walk");
            chk("walk.lit.out", int'(out_m), i);
            chk("walk.lit.mh",  int'(mh_m), 0);
        end
        step(16'h0008, 1'b1, "w8");  chk("w8.lit", int'(out_m), 3);
        step(16'h0040, 1'b1, "w40"); chk("w40.lit", int'(out_m), 6);

        // Multi-hot tables, literal expectations
        for (int i = 0; i < 5; i++) begin
            step(tbl_in[i], 1'b1, "mh1");
            chk("mh1.lit.out",   int'(out_m), tbl_msb[i]);
            chk("mh1.lit.valid", int'(valid_m), 1);
            chk("mh1.lit.mh",    int'(mh_m), 1);
        end
        for (int i = 0; i < 5; i++) begin
            step(tbl0_in[i], 1'b1, "mh0");
            chk("mh0.lit.out",   int'(out_l), tbl0_o[i]);
            chk("mh0.lit.valid", int'(valid_l), 1);
            chk("mh0.lit.mh",    int'(mh_l), tbl0_mh[i]);
        end

        // Zero input vs bit 0
        step(16'h0000, 1'b1, "zero");
        chk("zero.lit.valid", int'(valid_m), 0);
        step(16'h0001, 1'b1, "bit0");
        chk("bit0.lit.out",   int'(out_m), 0);
        chk("bit0.lit.valid", int'(valid_m), 1);

        // Enable gating, then enabled exactly one cycle later
        step(16'h0008, 1'b0, "gate");
        chk("gate.lit.valid", int'(valid_m), 0);
        step(16'h0008, 1'b1, "ungate");
        chk("ungate.lit.out",   int'(out_m), 3);
        chk("ungate.lit.valid", int'(valid_m), 1);

        // Asynchronous reset mid-cycle, no clock edge in between
        step(16'h00F0, 1'b1, "pre_arst");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out",   int'(out_m), 0);
        chk("arst.valid", int'(valid_m), 0);
        chk("arst.mh",    int'(mh_m), 0);
        chk("arst.lsb.valid", int'(valid_l), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(16'h0300, 1'b1, "post_arst");
        chk("post_arst.lit.out", int'(out_m), 9);

        // Randomized: sparse and dense vectors, enable toggling
        for (int n = 0; n < 300; n++) begin
            logic [15:0] v;
            case ($urandom_range(0, 3))
                0: v = 16'h1 << $urandom_range(0, 15);
                1: v = 16'($urandom) & 16'($urandom) & 16'($urandom);
                2: v = 16'h0000;
                default: v = 16'($urandom);
            endcase
            step(v, ($urandom_range(0, 3) != 0), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
